// File: rtl/rx_descrambler.sv
// Receive descrambler for the 1 + x^39 + x^58 self-synchronising scrambler,
// plus the clause 49 BER monitor that counts invalid sync headers per window.
module rx_descrambler #(
  parameter int BER_WINDOW    = 19531,
  parameter int BER_THRESHOLD = 16
) (
  input  logic        i_rxc,
  input  logic        i_reset_n,
  input  logic        i_rx_valid,
  input  logic [1:0]  i_rx_header,
  input  logic [63:0] i_rxd,
  input  logic        i_block_lock,
  output logic        o_rx_valid,
  output logic [1:0]  o_rx_header,
  output logic [63:0] o_rxd,
  output logic        o_hi_ber,
  output logic [5:0]  o_err_count
);

  localparam int              WIN_W    = (BER_WINDOW > 1) ? $clog2(BER_WINDOW) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(BER_WINDOW - 1);
  localparam logic [6:0]      THRESH   = 7'(BER_THRESHOLD);

  // Only bits 63:6 of the previous scrambled block are ever reached by the taps.
  logic [63:6]      prev_rxd;
  logic [63:0]      descrambled;
  logic [WIN_W-1:0] win_cnt;
  logic             invalid_hdr;
  logic [6:0]       err_sum;

  // Bit i xors with the received bits 39 and 58 positions earlier in the stream.
  assign descrambled = i_rxd
                     ^ {i_rxd[24:0], prev_rxd[63:25]}
                     ^ {i_rxd[5:0],  prev_rxd[63:6]};

  assign invalid_hdr = i_rx_valid && ((i_rx_header == 2'b00) || (i_rx_header == 2'b11));
  assign err_sum     = {1'b0, o_err_count} + 7'(invalid_hdr);

  always_ff @(posedge i_rxc or negedge i_reset_n) begin
    if (!i_reset_n) begin
      prev_rxd    <= '0;
      o_rxd       <= '0;
      o_rx_header <= '0;
      o_rx_valid  <= 1'b0;
    end else begin
      o_rx_valid <= i_rx_valid;
      if (i_rx_valid) begin
        prev_rxd    <= i_rxd[63:6];
        o_rxd       <= descrambled;
        o_rx_header <= i_rx_header;
      end
    end
  end

  // Lock loss takes priority over any error on the same block.
  always_ff @(posedge i_rxc or negedge i_reset_n) begin
    if (!i_reset_n) begin
      win_cnt     <= '0;
      o_err_count <= '0;
      o_hi_ber    <= 1'b0;
    end else if (!i_block_lock) begin
      win_cnt     <= '0;
      o_err_count <= '0;
      o_hi_ber    <= 1'b0;
    end else if (i_rx_valid) begin
      if (win_cnt == WIN_LAST) begin
        win_cnt     <= '0;
        o_err_count <= '0;
        o_hi_ber    <= (err_sum >= THRESH);
      end else begin
        win_cnt     <= win_cnt + WIN_W'(1);
        o_err_count <= (err_sum > 7'd63) ? 6'd63 : err_sum[5:0];
        if (err_sum >= THRESH)
          o_hi_ber <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rx_descrambler.sv
// Directed bench for rx_descrambler: hand-computed descramble vectors, a serial
// TX scrambler model for streamed payloads, and BER window/threshold sequences.
module tb_rx_descrambler;

  localparam int BER_WINDOW    = 64;
  localparam int BER_THRESHOLD = 16;

  logic        i_rxc = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_rx_valid = 1'b0;
  logic [1:0]  i_rx_header = 2'b00;
  logic [63:0] i_rxd = '0;
  logic        i_block_lock = 1'b0;
  logic        o_rx_valid;
  logic [1:0]  o_rx_header;
  logic [63:0] o_rxd;
  logic        o_hi_ber;
  logic [5:0]  o_err_count;

  int          compared = 0;
  int          mismatched = 0;
  logic [63:0] txPrev = '0;
  logic [63:0] lastPayload = '0;
  logic [1:0]  lastHeader = '0;

  rx_descrambler #(.BER_WINDOW(BER_WINDOW), .BER_THRESHOLD(BER_THRESHOLD)) dut (
    .i_rxc(i_rxc), .i_reset_n(i_reset_n), .i_rx_valid(i_rx_valid),
    .i_rx_header(i_rx_header), .i_rxd(i_rxd), .i_block_lock(i_block_lock),
    .o_rx_valid(o_rx_valid), .o_rx_header(o_rx_header), .o_rxd(o_rxd),
    .o_hi_ber(o_hi_ber), .o_err_count(o_err_count)
  );

  always #5 i_rxc = ~i_rxc;

  // Serial model of the transmit scrambler: each bit uses bits 39 and 58 back.
  function automatic logic [63:0] scrambleBlock(input logic [63:0] d, input logic [63:0] prev);
    logic [127:0] t;
    t = {64'h0, prev};
    for (int i = 0; i < 64; i++)
      t[64+i] = d[i] ^ t[64+i-39] ^ t[64+i-58];
    return t[127:64];
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [1:0] hdr,
                               input logic [63:0] data, input logic lock);
    i_rx_valid   = valid;
    i_rx_header  = hdr;
    i_rxd        = data;
    i_block_lock = lock;
    @(posedge i_rxc);
    #1;
  endtask

  task automatic sendBlock(input logic [1:0] hdr, input logic [63:0] payload,
                           input logic lock, input bit checkData);
    logic [63:0] sc;
    sc = scrambleBlock(payload, txPrev);
    txPrev = sc;
    applyStimulus(1'b1, hdr, sc, lock);
    lastPayload = payload;
    lastHeader  = hdr;
    if (checkData) begin
      checkOutput("rxd", o_rxd, payload);
      checkOutput("rx_header", 64'(o_rx_header), 64'(hdr));
      checkOutput("rx_valid", 64'(o_rx_valid), 64'd1);
    end
  endtask

  task automatic sendRun(input int n, input logic [1:0] hdr, input logic lock);
    for (int k = 0; k < n; k++)
      sendBlock(hdr, {32'hA5A5_0000, 32'(k)}, lock, 1'b0);
  endtask

  task automatic checkBer(input string tag, input logic expHi, input logic [5:0] expErr);
    checkOutput({tag, "_hi_ber"}, 64'(o_hi_ber), 64'(expHi));
    checkOutput({tag, "_err_count"}, 64'(o_err_count), 64'(expErr));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_rxd"}, o_rxd, 64'h0);
    checkOutput({tag, "_rx_header"}, 64'(o_rx_header), 64'h0);
    checkOutput({tag, "_rx_valid"}, 64'(o_rx_valid), 64'h0);
    checkBer(tag, 1'b0, 6'd0);
  endtask

  task automatic pauseCycle(input logic [1:0] hdr, input logic lock);
    applyStimulus(1'b0, hdr, 64'hBADC_0FFE_E0DD_F00D, lock);
    checkOutput("pause_rx_valid", 64'(o_rx_valid), 64'd0);
    checkOutput("pause_rxd_held", o_rxd, lastPayload);
    checkOutput("pause_hdr_held", 64'(o_rx_header), 64'(lastHeader));
  endtask

  initial begin
    #12;
    checkAllZero("reset");
    i_reset_n = 1'b1;

    // Hand vectors starting from a zeroed descrambler state.
    applyStimulus(1'b1, 2'b01, 64'h8000_0000_0000_0001, 1'b0);
    checkOutput("hand_a_rxd", o_rxd, 64'h8400_0080_0000_0001);
    checkOutput("hand_a_hdr", 64'(o_rx_header), 64'h1);
    checkOutput("hand_a_valid", 64'(o_rx_valid), 64'h1);
    applyStimulus(1'b1, 2'b10, 64'h0, 1'b0);
    checkOutput("hand_b_rxd", o_rxd, 64'h0200_0040_0000_0000);
    checkOutput("hand_b_hdr", 64'(o_rx_header), 64'h2);

    // Scrambler model starts from unrelated state; output is valid from block 2.
    txPrev = 64'hDEAD_BEEF_1234_5678;
    sendBlock(2'b10, 64'h0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) sendBlock(2'b10, 64'h0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) sendBlock(2'b01, 64'h0000_0000_0000_001E, 1'b0, 1'b1);
    pauseCycle(2'b00, 1'b0);
    sendBlock(2'b01, 64'h0000_0000_0000_001E, 1'b0, 1'b1);

    // Window 1: 15 errors, a pause, then the 16th error sets hi_ber.
    sendRun(15, 2'b00, 1'b1);
    checkBer("w1_15", 1'b0, 6'd15);
    pauseCycle(2'b00, 1'b1);
    checkBer("w1_pause", 1'b0, 6'd15);
    sendBlock(2'b11, 64'h1122_3344_5566_7788, 1'b1, 1'b1);
    checkBer("w1_16", 1'b1, 6'd16);
    sendRun(47, 2'b01, 1'b1);
    checkBer("w1_62", 1'b1, 6'd16);
    sendBlock(2'b10, 64'h0F0F_0F0F_0F0F_0F0F, 1'b1, 1'b1);
    checkBer("w1_end", 1'b1, 6'd0);

    // Window 2: only 3 errors, hi_ber drops after the last block.
    sendRun(3, 2'b00, 1'b1);
    checkBer("w2_3", 1'b1, 6'd3);
    sendRun(60, 2'b10, 1'b1);
    checkBer("w2_62", 1'b1, 6'd3);
    sendBlock(2'b01, 64'h0, 1'b1, 1'b0);
    checkBer("w2_end", 1'b0, 6'd0);

    // Window 3: 15 errors, the 16th lands on the final block.
    sendRun(15, 2'b11, 1'b1);
    checkBer("w3_15", 1'b0, 6'd15);
    sendRun(48, 2'b01, 1'b1);
    checkBer("w3_62", 1'b0, 6'd15);
    sendBlock(2'b00, 64'hCAFE_0000_0000_BABE, 1'b1, 1'b1);
    checkBer("w3_end", 1'b1, 6'd0);

    // Window 4: lock drops together with an invalid header.
    sendRun(10, 2'b00, 1'b1);
    checkBer("w4_10", 1'b1, 6'd10);
    sendBlock(2'b00, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b1);
    checkBer("lockloss", 1'b0, 6'd0);
    sendBlock(2'b11, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b1);
    checkBer("unlocked", 1'b0, 6'd0);

    // Asynchronous reset in mid-cycle, then resynchronisation.
    i_reset_n = 1'b1;
    #2 i_reset_n = 1'b0;
    #1 checkAllZero("async_reset");
    #2 i_reset_n = 1'b1;
    sendBlock(2'b01, 64'h0000_0000_0000_001E, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) sendBlock(2'b01, 64'h0000_0000_0000_001E, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
